// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: shares the single-port DRAM between the MEM stage and a host/debug port.
// Core has priority, bounded by a saturating host starvation counter.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              clear,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [2:0]        core_func3,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wren,
    output logic [2:0]        mem_func3,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int unsigned     CNT_W      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
    localparam logic [2:0]      FUNC3_WORD = 3'b010;

    logic [CNT_W-1:0]  waitCntQ, waitCntD;
    logic              hostPendQ;
    logic              hostRdPendQ;
    logic              coreRvalidQ;
    logic [DATA_W-1:0] hostRdataQ;

    logic hostElig;
    logic hostGnt;
    logic coreGnt;

    // hostPendQ masks the ack cycle so a still-held request is not granted twice.
    assign hostElig = host_req & ~hostPendQ;

    // The counter saturates at WAIT_LIMIT, so equality is the "reached limit" test.
    assign hostGnt = ~clear & hostElig & (~core_req | (waitCntQ == WAIT_LIMIT));
    assign coreGnt = ~clear & core_req & ~hostGnt;

    assign core_stall = ~clear & core_req & ~coreGnt;

    always_comb begin
        waitCntD = waitCntQ;
        if (hostGnt || !host_req) begin
            waitCntD = '0;
        end else if (hostElig && (waitCntQ != WAIT_LIMIT)) begin
            waitCntD = waitCntQ + CNT_W'(1);
        end
    end

    always_comb begin
        mem_addr  = core_addr;
        mem_din   = core_wdata;
        mem_func3 = core_func3;
        mem_wren  = 1'b0;
        if (hostGnt) begin
            mem_addr  = host_addr;
            mem_din   = host_wdata;
            mem_func3 = FUNC3_WORD;
            mem_wren  = host_we;
        end else if (coreGnt) begin
            mem_wren  = core_we;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            waitCntQ    <= '0;
            hostPendQ   <= 1'b0;
            hostRdPendQ <= 1'b0;
            coreRvalidQ <= 1'b0;
            hostRdataQ  <= '0;
        end else begin
            waitCntQ    <= waitCntD;
            hostPendQ   <= hostGnt;
            hostRdPendQ <= hostGnt & ~host_we;
            coreRvalidQ <= coreGnt & ~core_we;
            if (hostRdPendQ) begin
                hostRdataQ <= mem_dout;
            end
        end
    end

    // The ack register doubles as the pending flag: both follow the grant by one cycle.
    assign host_ack    = hostPendQ;
    assign core_rvalid = coreRvalidQ;
    assign core_rdata  = mem_dout;
    assign host_rdata  = hostRdPendQ ? mem_dout : hostRdataQ;

    grant_exclusive: assert property (@(posedge clock) disable iff (clear) !(hostGnt && coreGnt));
    wait_saturates:  assert property (@(posedge clock) disable iff (clear) waitCntQ <= WAIT_LIMIT);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios on MAX_WAIT=4 and MAX_WAIT=0 instances, then
// randomized traffic checked against a transaction-level model with a shadow memory.
module tb_dmem_arbiter;

    localparam int MW = 4;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [7:0]  core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic [2:0]  core_func3 = '0;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [7:0]  host_addr = '0;
    logic [31:0] host_wdata = '0;

    logic        core_stall, core_rvalid, host_ack, mem_wren;
    logic [31:0] core_rdata, host_rdata, mem_din, mem_dout;
    logic [7:0]  mem_addr;
    logic [2:0]  mem_func3;

    logic        zStall, zRvalid, zAck, zWren;
    logic [31:0] zRdata, zHostRdata, zDin, zDout;
    logic [7:0]  zAddr;
    logic [2:0]  zFunc3;

    logic [31:0] ram [256] = '{default: '0};
    logic [31:0] shadow [256];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_wren) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    assign zDout = 32'h0;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_WAIT(MW)) dut (
        .clock(clock), .clear(clear),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_func3(core_func3),
        .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wren(mem_wren),
        .mem_func3(mem_func3), .mem_dout(mem_dout)
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_WAIT(0)) dutZ (
        .clock(clock), .clear(clear),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_func3(core_func3),
        .core_stall(zStall), .core_rvalid(zRvalid), .core_rdata(zRdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(zAck), .host_rdata(zHostRdata),
        .mem_addr(zAddr), .mem_din(zDin), .mem_wren(zWren),
        .mem_func3(zFunc3), .mem_dout(zDout)
    );

    task automatic idle_inputs();
        core_req = 1'b0; core_we = 1'b0; host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        clear = 1'b1; core_req = 1'b1; core_we = 1'b1; host_req = 1'b1; host_we = 1'b1;
        #1;
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", core_stall); end
        checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b want 0", mem_wren); end
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", host_ack); end
        checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", core_rvalid); end
        checks++; if (host_rdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h want 0", host_rdata); end
        @(negedge clock);
        idle_inputs(); clear = 1'b0;
    endtask

    task automatic test_host_idle();
        @(negedge clock);
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (mem_wren !== 1'b1) begin errors++; $display("FAIL hw_wren: got %b want 1", mem_wren); end
        checks++; if (mem_addr !== 8'h10) begin errors++; $display("FAIL hw_addr: got %h want 10", mem_addr); end
        checks++; if (mem_din !== 32'hDEADBEEF) begin errors++; $display("FAIL hw_din: got %h want deadbeef", mem_din); end
        checks++; if (mem_func3 !== 3'b010) begin errors++; $display("FAIL hw_func3: got %b want 010", mem_func3); end
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL hw_ack_n: got %b want 0", host_ack); end
        @(negedge clock); host_req = 1'b0; #1;
        checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL hw_ack_n1: got %b want 1", host_ack); end
        @(negedge clock); #1;
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL hw_ack_n2: got %b want 0", host_ack); end
        @(negedge clock);
        host_req = 1'b1; host_we = 1'b0; host_wdata = 32'h0;
        #1;
        checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL hr_wren: got %b want 0", mem_wren); end
        @(negedge clock); host_req = 1'b0; #1;
        checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL hr_ack: got %b want 1", host_ack); end
        checks++; if (host_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL hr_data: got %h want deadbeef", host_rdata); end
        @(negedge clock); #1;
        checks++; if (host_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL hr_hold: got %h want deadbeef", host_rdata); end
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL hr_ack_off: got %b want 0", host_ack); end
    endtask

    task automatic test_core();
        @(negedge clock);
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10; core_func3 = 3'b010;
        #1;
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL lw_stall: got %b want 0", core_stall); end
        checks++; if (mem_func3 !== 3'b010) begin errors++; $display("FAIL lw_func3: got %b want 010", mem_func3); end
        @(negedge clock);
        core_func3 = 3'b000;
        #1;
        checks++; if (core_rvalid !== 1'b1) begin errors++; $display("FAIL lw_rvalid: got %b want 1", core_rvalid); end
        checks++; if (core_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h want deadbeef", core_rdata); end
        checks++; if (mem_func3 !== 3'b000) begin errors++; $display("FAIL lb_func3: got %b want 000", mem_func3); end
        @(negedge clock); idle_inputs(); #1;
        checks++; if (core_rvalid !== 1'b1) begin errors++; $display("FAIL lb_rvalid: got %b want 1", core_rvalid); end
        @(negedge clock); #1;
        checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_off: got %b want 0", core_rvalid); end
    endtask

    task automatic test_contention();
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            core_req = 1'b1; core_we = 1'b0; core_addr = 8'h11; core_func3 = 3'b010;
            host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
            #1;
            if (c <= 4) begin
                checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL cont_stall_c%0d: got %b want 0", c, core_stall); end
            end else if (c == 5) begin
                checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL cont_stall_c5: got %b want 1", core_stall); end
                checks++; if (mem_addr !== 8'h10) begin errors++; $display("FAIL cont_addr_c5: got %h want 10", mem_addr); end
            end else begin
                checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL cont_ack_c6: got %b want 1", host_ack); end
                checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL cont_stall_c6: got %b want 0", core_stall); end
            end
        end
        @(negedge clock); idle_inputs();
        @(negedge clock);
    endtask

    task automatic test_max_wait_zero();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            core_req = 1'b1; core_we = 1'b0; core_addr = 8'h11;
            host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
            #1;
            if (c == 1) begin
                checks++; if (zStall !== 1'b1) begin errors++; $display("FAIL mw0_stall_c1: got %b want 1", zStall); end
                checks++; if (zAddr !== 8'h10) begin errors++; $display("FAIL mw0_addr_c1: got %h want 10", zAddr); end
            end else if (c == 2) begin
                checks++; if (zAck !== 1'b1) begin errors++; $display("FAIL mw0_ack_c2: got %b want 1", zAck); end
                checks++; if (zStall !== 1'b0) begin errors++; $display("FAIL mw0_stall_c2: got %b want 0", zStall); end
            end else begin
                checks++; if (zAck !== 1'b0) begin errors++; $display("FAIL mw0_ack_c3: got %b want 0", zAck); end
            end
        end
        @(negedge clock); idle_inputs();
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        @(negedge clock);
        clear = 1'b1; host_req = 1'b0; core_req = 1'b1; core_we = 1'b1;
        #1;
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL rm_ack: got %b want 0", host_ack); end
        checks++; if (host_rdata !== 32'h0) begin errors++; $display("FAIL rm_hrdata: got %h want 0", host_rdata); end
        checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL rm_wren: got %b want 0", mem_wren); end
        @(negedge clock); clear = 1'b0; idle_inputs(); #1;
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL rm_ack_after: got %b want 0", host_ack); end
        @(negedge clock); #1;
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL rm_ack_after2: got %b want 0", host_ack); end
    endtask

    task automatic test_random();
        int          lost = 0;
        bit          blocked = 0, hostWaiting = 0, prevCoreRd = 0, prevHostRd = 0;
        bit          hostElig, hostWin, coreWin, expWren;
        logic [31:0] prevCoreData = '0, prevHostData = '0, held = '0, expHr;
        logic [7:0]  expAddr;
        logic [2:0]  expF3;
        for (int a = 0; a < 256; a++) shadow[a] = ram[a];
        @(negedge clock); clear = 1'b1; idle_inputs();
        @(negedge clock); clear = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            core_req   = ($urandom_range(0, 9) < 7);
            core_we    = 1'($urandom_range(0, 1));
            core_addr  = 8'h20 + 8'($urandom_range(0, 15));
            core_wdata = $urandom();
            core_func3 = 3'($urandom_range(0, 7));
            if (!hostWaiting) begin
                host_req   = 1'($urandom_range(0, 1));
                host_we    = 1'($urandom_range(0, 1));
                host_addr  = 8'h20 + 8'($urandom_range(0, 15));
                host_wdata = $urandom();
            end
            #1;
            hostElig = host_req && !blocked;
            hostWin  = hostElig && (!core_req || lost >= MW);
            coreWin  = core_req && !hostWin;
            expWren  = (coreWin && core_we) || (hostWin && host_we);
            expAddr  = hostWin ? host_addr : core_addr;
            expF3    = hostWin ? 3'b010 : core_func3;
            expHr    = prevHostRd ? prevHostData : held;
            checks++; if (core_stall !== (core_req && !coreWin)) begin errors++; $display("FAIL rnd_stall@%0d: got %b want %b", i, core_stall, core_req && !coreWin); end
            checks++; if (mem_wren !== expWren) begin errors++; $display("FAIL rnd_wren@%0d: got %b want %b", i, mem_wren, expWren); end
            checks++; if (mem_addr !== expAddr) begin errors++; $display("FAIL rnd_addr@%0d: got %h want %h", i, mem_addr, expAddr); end
            checks++; if (mem_func3 !== expF3) begin errors++; $display("FAIL rnd_func3@%0d: got %b want %b", i, mem_func3, expF3); end
            checks++; if (host_ack !== blocked) begin errors++; $display("FAIL rnd_ack@%0d: got %b want %b", i, host_ack, blocked); end
            checks++; if (core_rvalid !== prevCoreRd) begin errors++; $display("FAIL rnd_rvalid@%0d: got %b want %b", i, core_rvalid, prevCoreRd); end
            if (prevCoreRd) begin
                checks++; if (core_rdata !== prevCoreData) begin errors++; $display("FAIL rnd_crdata@%0d: got %h want %h", i, core_rdata, prevCoreData); end
            end
            checks++; if (host_rdata !== expHr) begin errors++; $display("FAIL rnd_hrdata@%0d: got %h want %h", i, host_rdata, expHr); end
            held         = expHr;
            prevCoreRd   = coreWin && !core_we;
            prevCoreData = shadow[core_addr];
            prevHostRd   = hostWin && !host_we;
            prevHostData = shadow[host_addr];
            if (coreWin && core_we) shadow[core_addr] = core_wdata;
            if (hostWin && host_we) shadow[host_addr] = host_wdata;
            if (hostWin || !host_req) lost = 0;
            else if (hostElig && lost < MW) lost++;
            blocked     = hostWin;
            hostWaiting = hostElig && !hostWin;
        end
        @(negedge clock); idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_host_idle();
        test_core();
        test_contention();
        test_max_wait_zero();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data RAM between the pipeline MEM stage (core port) and an external host/debug port used for program loading and memory inspection. Grants at most one access per cycle, with core priority bounded by a host starvation counter. Drives the DRAM address, data, write-enable and func3 inputs. Back-pressures the pipeline through `core_stall`, which the integrator ORs into the register-enable stall chain alongside `fpu_inprogress`.

## Interface
- `ADDR_W`, 8: DRAM word address width.
- `DATA_W`, 32: data width.
- `MAX_WAIT`, 4: number of contended cycles the host may lose before it is forced to win; 0 gives the host absolute priority.

- `clock` in 1: single clock; all state updates on the rising edge.
- `clear` in 1: asynchronous, active-high reset.
- `core_req` in 1: MEM stage requests an access (MemRead | MemWrite).
- `core_we` in 1: core write.
- `core_addr` in ADDR_W: core address.
- `core_wdata` in DATA_W: core store data.
- `core_func3` in 3: core access size/sign, passed to DRAM unchanged.
- `core_stall` out 1: core request not granted this cycle (combinational).
- `core_rvalid` out 1: core read data valid this cycle.
- `core_rdata` out DATA_W: equals `mem_dout`.
- `host_req` in 1: level request, held until `host_ack`.
- `host_we` in 1: host write.
- `host_addr` in ADDR_W: host address.
- `host_wdata` in DATA_W: host write data.
- `host_ack` out 1: one-cycle completion pulse.
- `host_rdata` out DATA_W: last host read result.
- `mem_addr` out ADDR_W: DRAM address.
- `mem_din` out DATA_W: DRAM write data.
- `mem_wren` out 1: DRAM write enable.
- `mem_func3` out 3: DRAM access size.
- `mem_dout` in DATA_W: DRAM read data, valid one cycle after its address is presented.

## Operation
- **Eligibility.** The host is eligible when `host_req`=1 and `host_pend`=0. `host_pend` is a register set in each host grant cycle and cleared in the following cycle, which is the ack cycle. This blocks a second grant of the same held request.
- **Grant decision** (combinational):
  - `host_gnt` = host eligible AND (`core_req`=0 OR `wait_cnt` ≥ MAX_WAIT).
  - `core_gnt` = `core_req` AND NOT `host_gnt`.
- **`core_stall`** = `core_req` AND NOT `core_gnt`.
- **Memory mux.**
  - `core_gnt`: mem_* take the core fields.
  - `host_gnt`: mem_* take the host fields, with `mem_func3` = 3'b010 (word).
  - Neither: `mem_wren`=0 and the address holds the core fields.
  - `mem_wren` = (`core_gnt` & `core_we`) | (`host_gnt` & `host_we`).
- **Starvation counter `wait_cnt`** (width clog2(MAX_WAIT+1), saturating):
  - Increments when the host is eligible and not granted.
  - Clears on `host_gnt`, or when `host_req` drops.
  - Never wraps.
- **Core read response.** `core_rvalid` is a register set to `core_gnt & ~core_we`, so it is high the cycle after the grant. `core_rdata` = `mem_dout`.
- **Host response.**
  - `host_ack` is a register, set to `host_gnt` (reads and writes alike).
  - On an ack cycle following a host read, `host_rdata` = `mem_dout`. The same value is captured into a hold register at the end of that cycle.
  - At all other times `host_rdata` = the hold register.
  - Host writes leave the hold register unchanged.
- **Simultaneous requests.** With `wait_cnt` < MAX_WAIT the core wins and the host waits. With `wait_cnt` = MAX_WAIT the host wins and the core stalls exactly one cycle. Because the counter clears on the host grant, the core always wins the next contended cycle unless MAX_WAIT=0.
- **Reset.** While `clear`=1: `core_stall`, `core_rvalid`, `host_ack`, `mem_wren` are 0; `host_rdata`, `wait_cnt`, `host_pend` are 0. A pending ack or rvalid in flight when reset asserts is discarded, not replayed.

## Timing
- Arbitration is same-cycle: grant and mem_* are valid in cycle N when the requests are stable in N.
- Read data: cycle N+1 for both ports. Writes commit at the N edge.
- Host latency from `host_req` rising is 1 cycle (grant) plus the ack cycle when uncontended. The worst case under continuous core traffic is MAX_WAIT+1 cycles to grant.
- The host may drop `host_req` in the ack cycle. If it is still high in the ack cycle it is ignored; if still high the cycle after the ack, it is treated as a new request.
- Throughput is one access per cycle. Host requests held continuously are granted at most every second cycle.

## Test plan
- **Reset mid-access.** Assert `clear` in the cycle after a host read grant → `host_ack`=0, `host_rdata`=0, `mem_wren`=0 during reset. After reset deasserts, no ack is issued.
- **Host idle.** Host write addr 0x10 data 0xDEADBEEF, core idle → `mem_wren`=1 in N, `host_ack`=1 in N+1 only. A subsequent host read of 0x10 returns `host_rdata`=0xDEADBEEF in its ack cycle and holds it afterwards.
- **Core uncontended.** Core `lw` from 0x10 (func3=010), host idle → `core_stall`=0 and `core_rvalid`=1 at N+1 with `core_rdata`=0xDEADBEEF. `mem_func3` follows the core's value (e.g. 000 for `lb`).
- **Contention, MAX_WAIT=4.** Core and host both requesting continuously → core granted 4 cycles with `core_stall`=0. Cycle 5: `host_gnt`, `core_stall`=1. Cycle 6: `host_ack` pulses and the core resumes.
- **MAX_WAIT=0.** Simultaneous requests → host granted first and the core stalls exactly one cycle. The held `host_req` is not re-granted in the ack cycle.
